// File: rtl/pkt_reader_pkg.sv
// Shared types and default widths for the packet reader and its descriptor FIFO.
package pkt_reader_pkg;

   localparam int unsigned ADDR_W_DEF = 8;
   localparam int unsigned DATA_W_DEF = 8;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      FETCH,
      WAIT,
      SEND,
      GAP,
      DROP
   } state_t;

   typedef struct packed {
      logic [ADDR_W_DEF-1:0] last_addr;
      logic [7:0]            data_size;
   } desc_t;

endpackage

// File: rtl/pkt_reader_if.sv
// Descriptor, packet RAM read and byte-stream signals of the packet reader.
interface pkt_reader_if
   import pkt_reader_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned DATA_W = DATA_W_DEF
);

   logic              desc_empty;
   logic [ADDR_W-1:0] desc_last_addr;
   logic [7:0]        desc_data_size;
   logic              desc_rd_en;

   logic              mem_rd_en;
   logic [ADDR_W-1:0] mem_rd_addr;
   logic [DATA_W-1:0] mem_rd_data;

   logic [DATA_W-1:0] tx_data;
   logic              tx_valid;
   logic              tx_last;
   logic              tx_ready;

   // master: the reader itself; slave: FIFO, RAM and serializer side
   modport master (
      input  desc_empty, desc_last_addr, desc_data_size, mem_rd_data, tx_ready,
      output desc_rd_en, mem_rd_en, mem_rd_addr, tx_data, tx_valid, tx_last
   );

   modport slave (
      output desc_empty, desc_last_addr, desc_data_size, mem_rd_data, tx_ready,
      input  desc_rd_en, mem_rd_en, mem_rd_addr, tx_data, tx_valid, tx_last
   );

endinterface

// File: rtl/pkt_reader.sv
// Pops packet descriptors, reads the bytes from the packet RAM and streams them out.
// Define PKT_READER_LEN_HDR_EN to prefix each packet with a length header byte.
module pkt_reader
   import pkt_reader_pkg::*;
#(
   parameter int unsigned ADDR_W     = ADDR_W_DEF,
   parameter int unsigned DATA_W     = DATA_W_DEF,
   parameter int unsigned GAP_CYCLES = 2
) (
   input  logic         clk,
   input  logic         rst,
   pkt_reader_if.master bus,
   output logic         busy,
   output logic         pkt_done
);

   localparam int unsigned GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
   localparam int unsigned GAP_W    = (GAP_LAST > 0) ? $clog2(GAP_LAST + 1) : 1;

   state_t            state;
   logic [ADDR_W-1:0] last_addr;
   logic [7:0]        size_q;
   logic [ADDR_W-1:0] addr;
   logic [7:0]        remaining;
   logic [GAP_W-1:0]  gap_cnt;
   logic [ADDR_W-1:0] start_addr;
`ifdef PKT_READER_LEN_HDR_EN
   logic              hdr_pend;
`endif

   // First byte of the packet; the region may wrap past the top of the RAM.
   always_comb begin
      start_addr = last_addr - ADDR_W'(size_q) + ADDR_W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state           <= IDLE;
         last_addr       <= '0;
         size_q          <= '0;
         addr            <= '0;
         remaining       <= '0;
         gap_cnt         <= '0;
         busy            <= 1'b0;
         pkt_done        <= 1'b0;
         bus.desc_rd_en  <= 1'b0;
         bus.mem_rd_en   <= 1'b0;
         bus.mem_rd_addr <= '0;
         bus.tx_data     <= '0;
         bus.tx_valid    <= 1'b0;
         bus.tx_last     <= 1'b0;
`ifdef PKT_READER_LEN_HDR_EN
         hdr_pend        <= 1'b0;
`endif
      end else begin
         bus.desc_rd_en <= 1'b0;
         bus.mem_rd_en  <= 1'b0;
         pkt_done       <= 1'b0;

         case (state)
            IDLE: begin
               if (!bus.desc_empty) begin
                  last_addr      <= bus.desc_last_addr;
                  size_q         <= bus.desc_data_size;
                  bus.desc_rd_en <= 1'b1;
                  busy           <= 1'b1;
                  state          <= LOAD;
               end
            end

            LOAD: begin
               if (size_q == '0) begin
                  state <= DROP;
               end else begin
                  addr            <= start_addr;
                  mem_rd_addr_set : begin
                     bus.mem_rd_addr <= start_addr;
                  end
                  remaining       <= size_q;
                  state           <= FETCH;
`ifdef PKT_READER_LEN_HDR_EN
                  // FETCH/WAIT are walked without a RAM read so the header keeps the payload latency
                  hdr_pend        <= 1'b1;
`else
                  bus.mem_rd_en   <= 1'b1;
`endif
               end
            end

            FETCH: begin
               state <= WAIT;
            end

            WAIT: begin
               bus.tx_data  <= bus.mem_rd_data;
               bus.tx_last  <= (remaining == 8'd1);
               bus.tx_valid <= 1'b1;
`ifdef PKT_READER_LEN_HDR_EN
               if (hdr_pend) begin
                  bus.tx_data <= DATA_W'(size_q);
                  bus.tx_last <= 1'b0;
               end
`endif
               state <= SEND;
            end

            SEND: begin
               if (bus.tx_ready) begin
                  bus.tx_valid <= 1'b0;
                  bus.tx_last  <= 1'b0;
`ifdef PKT_READER_LEN_HDR_EN
                  if (hdr_pend) begin
                     hdr_pend        <= 1'b0;
                     bus.mem_rd_en   <= 1'b1;
                     bus.mem_rd_addr <= addr;
                     state           <= FETCH;
                  end else
`endif
                  begin
                     remaining <= remaining - 8'd1;
                     addr      <= addr + ADDR_W'(1);
                     if (remaining == 8'd1) begin
                        pkt_done <= 1'b1;
                        gap_cnt  <= '0;
                        if (GAP_CYCLES == 0) begin
                           busy  <= 1'b0;
                           state <= IDLE;
                        end else begin
                           state <= GAP;
                        end
                     end else begin
                        bus.mem_rd_en   <= 1'b1;
                        bus.mem_rd_addr <= addr + ADDR_W'(1);
                        state           <= FETCH;
                     end
                  end
               end
            end

            GAP: begin
               if (gap_cnt == GAP_W'(GAP_LAST)) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end else begin
                  gap_cnt <= gap_cnt + GAP_W'(1);
               end
            end

            DROP: begin
               busy  <= 1'b0;
               state <= IDLE;
            end

            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pkt_reader.sv
// Directed bench for pkt_reader with a descriptor FIFO model and a synchronous RAM model.
module tb_pkt_reader;

   localparam int unsigned GAP = 2;

   logic clk = 1'b0;
   logic rst;
   logic busy;
   logic pkt_done;

   always #5 clk = ~clk;

   pkt_reader_if #(.ADDR_W(8), .DATA_W(8)) bus ();

   pkt_reader #(
      .ADDR_W    (8),
      .DATA_W    (8),
      .GAP_CYCLES(GAP)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .bus     (bus),
      .busy    (busy),
      .pkt_done(pkt_done)
   );

   // descriptor FIFO model: written by the stimulus, popped by desc_rd_en
   logic [7:0] fifo_la [16];
   logic [7:0] fifo_sz [16];
   logic [3:0] wr_ptr = '0;
   logic [3:0] rd_ptr = '0;

   assign bus.desc_empty     = (rd_ptr == wr_ptr);
   assign bus.desc_last_addr = fifo_la[rd_ptr];
   assign bus.desc_data_size = fifo_sz[rd_ptr];

   always @(posedge clk) begin
      if (bus.desc_rd_en && !bus.desc_empty) rd_ptr <= rd_ptr + 4'd1;
   end

   // packet RAM model, one-cycle read latency
   logic [7:0] ram [256];
   logic [7:0] rdata;
   always @(posedge clk) begin
      if (bus.mem_rd_en) rdata <= ram[bus.mem_rd_addr];
   end
   assign bus.mem_rd_data = rdata;

   // monitor, sampled on the falling edge
   logic [7:0] acc_bytes [$];
   logic       acc_last  [$];
   logic [7:0] addr_log  [$];
   int         done_cyc  [$];
   int         pop_cyc   [$];
   int         bad_pops = 0;
   int         cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (bus.tx_valid && bus.tx_ready) begin
         acc_bytes.push_back(bus.tx_data);
         acc_last.push_back(bus.tx_last);
      end
      if (bus.mem_rd_en) addr_log.push_back(bus.mem_rd_addr);
      if (pkt_done) done_cyc.push_back(cyc);
      if (bus.desc_rd_en) begin
         pop_cyc.push_back(cyc);
         if (bus.desc_empty) bad_pops++;
      end
   end

   typedef struct {
      logic [7:0]  last_addr;
      logic [7:0]  size;
      logic [31:0] bytes;       // payload, first byte in the top lane
      logic [7:0]  first_addr;
   } vec_t;

   vec_t vecs [4];
   int   tests = 0;
   int   fails = 0;

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [7:0] la, input logic [7:0] sz);
      fifo_la[wr_ptr] = la;
      fifo_sz[wr_ptr] = sz;
      wr_ptr = wr_ptr + 4'd1;
   endtask

   task automatic wait_done(input int target, input string name);
      for (int i = 0; i < 400 && done_cyc.size() < target; i++) tick();
      check(name, done_cyc.size(), target);
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 20 && busy; i++) tick();
   endtask

   task automatic check_stream(input string name, input vec_t v, input int base_b);
      logic [7:0] e [$];
      int         got;
`ifdef PKT_READER_LEN_HDR_EN
      e.push_back(v.size);
`endif
      for (int j = 0; j < int'(v.size); j++) e.push_back(v.bytes[31-8*j -: 8]);
      got = acc_bytes.size() - base_b;
      check({name, " byte count"}, got, e.size());
      for (int j = 0; j < e.size(); j++) begin
         if (j < got) begin
            check({name, " byte"}, int'(acc_bytes[base_b+j]), int'(e[j]));
            check({name, " tx_last"}, int'(acc_last[base_b+j]), int'(j == e.size() - 1));
         end
      end
   endtask

   task automatic run_vec(input int i);
      int base_b, base_a, base_d, base_p, lat;
      base_b = acc_bytes.size();
      base_a = addr_log.size();
      base_d = done_cyc.size();
      base_p = pop_cyc.size();
      push(vecs[i].last_addr, vecs[i].size);
      lat = 0;
      while (!bus.tx_valid && lat < 20) begin
         tick();
         lat++;
      end
      check("latency", lat, 4);
      wait_done(base_d + 1, "pkt_done");
      wait_idle();
      check_stream("vec", vecs[i], base_b);
      check("vec pops", pop_cyc.size() - base_p, 1);
      check("vec reads", addr_log.size() - base_a, int'(vecs[i].size));
      for (int j = 0; j < int'(vecs[i].size); j++) begin
         if (base_a + j < addr_log.size())
            check("vec rd_addr", int'(addr_log[base_a+j]), int'(8'(vecs[i].first_addr + 8'(j))));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1);
   end

   initial begin
      int         base_b, base_a, base_d, base_p, base_m, base_b2, base_p2;
      logic [7:0] exp_b2;

      rst = 1'b1;
      bus.tx_ready = 1'b0;
      for (int a = 0; a < 256; a++) ram[a[7:0]] = a[7:0] ^ 8'h5C;
      ram[8'h10] = 8'hAA; ram[8'h11] = 8'hBB; ram[8'h12] = 8'hCC; ram[8'h13] = 8'hDD;
      ram[8'hFF] = 8'h11; ram[8'h00] = 8'h22; ram[8'h01] = 8'h33;
      ram[8'h21] = 8'h5A;
      ram[8'h3F] = 8'hC3; ram[8'h40] = 8'h3C;
      for (int a = 0; a < 6; a++) ram[8'h80 + a[7:0]] = 8'h01 + a[7:0];

      vecs[0] = '{last_addr: 8'h13, size: 8'd4, bytes: 32'hAABBCCDD, first_addr: 8'h10};
      vecs[1] = '{last_addr: 8'h01, size: 8'd3, bytes: 32'h11223300, first_addr: 8'hFF};
      vecs[2] = '{last_addr: 8'h21, size: 8'd1, bytes: 32'h5A000000, first_addr: 8'h21};
      vecs[3] = '{last_addr: 8'h40, size: 8'd2, bytes: 32'hC33C0000, first_addr: 8'h3F};

      repeat (3) tick();
      check("reset outputs",
            int'({bus.tx_valid, bus.tx_last, bus.desc_rd_en, bus.mem_rd_en, busy, pkt_done}), 0);
      rst = 1'b0;
      bus.tx_ready = 1'b1;
      tick();

      for (int i = 0; i < 4; i++) run_vec(i);

      // backpressure on the second byte
      base_b = acc_bytes.size();
      base_d = done_cyc.size();
`ifdef PKT_READER_LEN_HDR_EN
      exp_b2 = vecs[0].bytes[31:24];
`else
      exp_b2 = vecs[0].bytes[23:16];
`endif
      push(vecs[0].last_addr, vecs[0].size);
      for (int i = 0; i < 50 && acc_bytes.size() <= base_b; i++) tick();
      bus.tx_ready = 1'b0;
      for (int i = 0; i < 10 && !bus.tx_valid; i++) tick();
      base_m = addr_log.size();
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("bp tx_valid", int'(bus.tx_valid), 1);
         check("bp tx_data", int'(bus.tx_data), int'(exp_b2));
      end
      tick();
      check("bp no extra read", addr_log.size() - base_m, 0);
      bus.tx_ready = 1'b1;
      wait_done(base_d + 1, "bp pkt_done");
      wait_idle();
      check_stream("bp", vecs[0], base_b);

      // zero-size descriptor is dropped, next one runs
      base_b = acc_bytes.size();
      base_a = addr_log.size();
      base_d = done_cyc.size();
      base_p = pop_cyc.size();
      push(8'h20, 8'd0);
      push(vecs[2].last_addr, vecs[2].size);
      wait_done(base_d + 1, "zero pkt_done");
      wait_idle();
      repeat (3) tick();
      check("zero done count", done_cyc.size() - base_d, 1);
      check("zero pops", pop_cyc.size() - base_p, 2);
      check("zero reads", addr_log.size() - base_a, 1);
      check_stream("zero", vecs[2], base_b);

      // back-to-back packets with inter-packet gap
      base_b = acc_bytes.size();
      base_d = done_cyc.size();
      base_p = pop_cyc.size();
      push(vecs[0].last_addr, vecs[0].size);
      push(vecs[3].last_addr, vecs[3].size);
      wait_done(base_d + 2, "b2b pkt_done");
      wait_idle();
      check("b2b pops", pop_cyc.size() - base_p, 2);
      if (pop_cyc.size() >= base_p + 2 && done_cyc.size() >= base_d + 1)
         check("b2b gap", pop_cyc[base_p+1] - done_cyc[base_d], GAP + 1);
`ifdef PKT_READER_LEN_HDR_EN
      check("b2b bytes", acc_bytes.size() - base_b, 8);
`else
      check("b2b bytes", acc_bytes.size() - base_b, 6);
`endif

      // asynchronous reset while the third byte waits in SEND
      base_b = acc_bytes.size();
      base_d = done_cyc.size();
      push(8'h85, 8'd6);
      push(vecs[0].last_addr, vecs[0].size);
      for (int i = 0; i < 50 && acc_bytes.size() < base_b + 2; i++) tick();
      bus.tx_ready = 1'b0;
      for (int i = 0; i < 10 && !bus.tx_valid; i++) tick();
      check("rst pre tx_valid", int'(bus.tx_valid), 1);
      #2;
      rst = 1'b1;
      #1;
      check("rst tx_valid", int'(bus.tx_valid), 0);
      check("rst busy", int'(busy), 0);
      check("rst desc_rd_en", int'(bus.desc_rd_en), 0);
      tick();
      tick();
      rst = 1'b0;
      check("rst release busy", int'(busy), 0);
      base_b2 = acc_bytes.size();
      base_p2 = pop_cyc.size();
      check("rst bytes before", base_b2 - base_b, 2);
      bus.tx_ready = 1'b1;
      wait_done(base_d + 1, "rst pkt_done");
      wait_idle();
      check("rst pops after", pop_cyc.size() - base_p2, 1);
      check_stream("rst next", vecs[0], base_b2);

      check("pop while empty", bad_pops, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
